// File: rtl/mod_counter_pkg.sv
// Shared definitions for the mod_counter slice: direction encodings,
// counter width helper and the BCD digit type.
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef logic [3:0] bcd_digit_t;

    // Bits needed to hold 0..modulus-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned modulus);
        int unsigned w;
        w = $clog2(modulus);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mod_counter_if.sv
// Control/status bundle of one mod_counter stage.
// master drives the controls and observes the count; slave is the counter.
interface mod_counter_if #(
    parameter int unsigned WIDTH = 6
);
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             load_err;

    modport master (
        output en, up_dn, clr, load, load_val,
        input  count, tc, load_err
    );

    modport slave (
        input  en, up_dn, clr, load, load_val,
        output count, tc, load_err
    );
endinterface

// File: rtl/mod_counter_bin2bcd_2dig.sv
// Combinational binary (0..99) to two-digit BCD converter.
module bin2bcd_2dig
    import counter_pkg::*;
(
    input  logic [6:0] bin,
    output bcd_digit_t tens,
    output bcd_digit_t ones
);

    assign tens = 4'(bin / 7'd10);
    assign ones = 4'(bin % 7'd10);

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo-N up/down counter with synchronous clear, parallel
// load, sticky load-range error and a combinational terminal-count strobe
// for cascading (stage k.en <= stage k-1.tc).
// Optional macro MOD_COUNTER_BCD_OUT_EN adds registered BCD outputs
// bcd_tens/bcd_ones, one clock behind count (MODULUS <= 100 only).
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned MODULUS = 60,
    parameter int unsigned WIDTH   = cnt_width(MODULUS)
) (
    input  logic              clk,
    input  logic              rst_n,
    mod_counter_if.slave      bus
`ifdef MOD_COUNTER_BCD_OUT_EN
    ,
    output bcd_digit_t        bcd_tens,
    output bcd_digit_t        bcd_ones
`endif
);

    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    if (MODULUS < 2 || MODULUS > 65536) begin : g_bad_modulus
        $error("mod_counter: MODULUS %0d outside 2..65536", MODULUS);
    end
    if ((64'd1 << WIDTH) < 64'(MODULUS)) begin : g_bad_width
        $error("mod_counter: WIDTH %0d too small for MODULUS %0d", WIDTH, MODULUS);
    end

    logic load_ok;
    assign load_ok = ({1'b0, bus.load_val} < MOD_EXT);

    // Terminal count: asserted in the cycle the next enabled edge wraps.
    assign bus.tc = bus.en & ((bus.up_dn == DIR_UP) ? (bus.count == MAX_C)
                                                    : (bus.count == '0));

    // Count register and sticky load error; priority clr > load > en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.count    <= '0;
            bus.load_err <= 1'b0;
        end else if (bus.clr) begin
            bus.count    <= '0;
            bus.load_err <= 1'b0;
        end else if (bus.load) begin
            if (load_ok) begin
                bus.count <= bus.load_val;
            end else begin
                bus.count    <= '0;
                bus.load_err <= 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up_dn == DIR_UP)
                bus.count <= (bus.count == MAX_C) ? '0 : bus.count + WIDTH'(1);
            else
                bus.count <= (bus.count == '0) ? MAX_C : bus.count - WIDTH'(1);
        end
    end

`ifdef MOD_COUNTER_BCD_OUT_EN
    if (MODULUS > 100) begin : g_bad_bcd
        $error("mod_counter: BCD output needs MODULUS <= 100, got %0d", MODULUS);
    end

    bcd_digit_t tens_c;
    bcd_digit_t ones_c;

    bin2bcd_2dig u_bin2bcd (
        .bin  (7'(bus.count)),
        .tens (tens_c),
        .ones (ones_c)
    );

    // BCD output register, one clock behind count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_tens <= '0;
            bcd_ones <= '0;
        end else begin
            bcd_tens <= tens_c;
            bcd_ones <= ones_c;
        end
    end
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter: mod-60 and mod-10 stages,
// plus a two-stage mod-60 cascade.
module tb_mod_counter;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    mod_counter_if #(.WIDTH(6)) bus_m ();
    mod_counter_if #(.WIDTH(4)) bus_s ();
    mod_counter_if #(.WIDTH(6)) bus_a ();
    mod_counter_if #(.WIDTH(6)) bus_b ();

`ifdef MOD_COUNTER_BCD_OUT_EN
    logic [3:0] m_tens, m_ones, s_tens, s_ones, a_tens, a_ones, b_tens, b_ones;
`endif

    mod_counter #(.MODULUS(60)) dut (
        .clk (clk), .rst_n (rst_n), .bus (bus_m)
`ifdef MOD_COUNTER_BCD_OUT_EN
        , .bcd_tens (m_tens), .bcd_ones (m_ones)
`endif
    );

    mod_counter #(.MODULUS(10)) dut10 (
        .clk (clk), .rst_n (rst_n), .bus (bus_s)
`ifdef MOD_COUNTER_BCD_OUT_EN
        , .bcd_tens (s_tens), .bcd_ones (s_ones)
`endif
    );

    mod_counter #(.MODULUS(60)) stage_a (
        .clk (clk), .rst_n (rst_n), .bus (bus_a)
`ifdef MOD_COUNTER_BCD_OUT_EN
        , .bcd_tens (a_tens), .bcd_ones (a_ones)
`endif
    );

    mod_counter #(.MODULUS(60)) stage_b (
        .clk (clk), .rst_n (rst_n), .bus (bus_b)
`ifdef MOD_COUNTER_BCD_OUT_EN
        , .bcd_tens (b_tens), .bcd_ones (b_ones)
`endif
    );

    assign bus_b.en = bus_a.tc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n = 1'b0;
        bus_m.en = 0; bus_m.up_dn = 1; bus_m.clr = 0; bus_m.load = 0; bus_m.load_val = '0;
        bus_s.en = 0; bus_s.up_dn = 1; bus_s.clr = 0; bus_s.load = 0; bus_s.load_val = '0;
        bus_a.en = 0; bus_a.up_dn = 1; bus_a.clr = 0; bus_a.load = 0; bus_a.load_val = '0;
        bus_b.up_dn = 1; bus_b.clr = 0; bus_b.load = 0; bus_b.load_val = '0;
        #2;
        check("reset_count", 32'(bus_m.count), 0);
        check("reset_err", 32'(bus_m.load_err), 0);
        step();
        step();
        check("reset_count_hold", 32'(bus_m.count), 0);
        check("reset_tc", 32'(bus_m.tc), 0);

        // Up-count through a full wrap.
        rst_n = 1'b1;
        bus_m.en = 1; bus_m.up_dn = 1;
        #1;
        for (int i = 0; i <= 60; i++) begin
            check("up_count", 32'(bus_m.count), 32'(i % 60));
            check("up_tc", 32'(bus_m.tc), 32'((i % 60) == 59));
            check("up_err", 32'(bus_m.load_err), 0);
            if (i < 60) step();
        end
        bus_m.en = 0;

        // Priority: clr beats load.
        bus_m.load = 1; bus_m.load_val = 6'd20;
        step();
        check("load_20", 32'(bus_m.count), 20);
        bus_m.clr = 1; bus_m.load_val = 6'd5;
        step();
        bus_m.clr = 0; bus_m.load = 0;
        check("clr_over_load", 32'(bus_m.count), 0);

        // Out-of-range load and sticky error.
        bus_m.load = 1; bus_m.load_val = 6'd63;
        step();
        check("bad_load_count", 32'(bus_m.count), 0);
        check("bad_load_err", 32'(bus_m.load_err), 1);
        bus_m.load = 0; bus_m.en = 1;
        step();
        check("err_sticky_en", 32'(bus_m.count), 1);
        check("err_sticky_en_flag", 32'(bus_m.load_err), 1);
        bus_m.en = 0; bus_m.load = 1; bus_m.load_val = 6'd10;
        step();
        check("err_sticky_load", 32'(bus_m.count), 10);
        check("err_sticky_load_flag", 32'(bus_m.load_err), 1);
        bus_m.load = 0; bus_m.clr = 1;
        step();
        bus_m.clr = 0;
        check("clr_err", 32'(bus_m.load_err), 0);
        check("clr_count", 32'(bus_m.count), 0);

        // tc gating at count 59.
        bus_m.load = 1; bus_m.load_val = 6'd59;
        step();
        bus_m.load = 0;
        #1;
        check("tc59_en0", 32'(bus_m.tc), 0);
        bus_m.en = 1; bus_m.up_dn = 1;
        #1;
        check("tc59_up", 32'(bus_m.tc), 1);
        bus_m.up_dn = 0;
        #1;
        check("tc59_dn", 32'(bus_m.tc), 0);
        step();
        check("dn_from_59", 32'(bus_m.count), 58);
        bus_m.en = 0; bus_m.up_dn = 1;

        // Mod-10 down-count wrap.
        bus_s.load = 1; bus_s.load_val = 4'd0;
        step();
        bus_s.load = 0; bus_s.en = 1; bus_s.up_dn = 0;
        #1;
        check("m10_start", 32'(bus_s.count), 0);
        check("m10_tc_at0", 32'(bus_s.tc), 1);
        step();
        check("m10_wrap9", 32'(bus_s.count), 9);
        check("m10_tc_at9", 32'(bus_s.tc), 0);
        step();
        check("m10_8", 32'(bus_s.count), 8);
        bus_s.en = 0; bus_s.load = 1; bus_s.load_val = 4'd0;
        step();
        bus_s.load = 0;
        #1;
        check("m10_tc_en0", 32'(bus_s.tc), 0);
        bus_s.load = 1; bus_s.load_val = 4'd10;
        step();
        check("m10_load10_count", 32'(bus_s.count), 0);
        check("m10_load10_err", 32'(bus_s.load_err), 1);
        bus_s.load_val = 4'd9;
        step();
        bus_s.load = 0;
        check("m10_load9", 32'(bus_s.count), 9);
        bus_s.en = 1; bus_s.up_dn = 1;
        step();
        bus_s.en = 0;
        check("m10_up_wrap", 32'(bus_s.count), 0);

        // Cascade A -> B.
        bus_a.load = 1; bus_a.load_val = 6'd59;
        bus_b.load = 1; bus_b.load_val = 6'd59;
        step();
        bus_a.load = 0; bus_b.load = 0; bus_a.en = 1;
        #1;
        check("casc_a_tc", 32'(bus_a.tc), 1);
        check("casc_b_tc", 32'(bus_b.tc), 1);
        step();
        check("casc_a_wrap", 32'(bus_a.count), 0);
        check("casc_b_wrap", 32'(bus_b.count), 0);
        bus_a.en = 0;
        bus_a.load = 1; bus_a.load_val = 6'd59;
        bus_b.load = 1; bus_b.load_val = 6'd58;
        step();
        bus_a.load = 0; bus_b.load = 0;
        check("casc_b_hold", 32'(bus_b.count), 58);
        bus_a.en = 1;
        step();
        bus_a.en = 0;
        check("casc_a_0", 32'(bus_a.count), 0);
        check("casc_b_59", 32'(bus_b.count), 59);
        step();
        check("casc_b_idle", 32'(bus_b.count), 59);

        // Async reset mid-count.
        bus_m.load = 1; bus_m.load_val = 6'd63;
        step();
        bus_m.load_val = 6'd30;
        step();
        bus_m.load = 0; bus_m.en = 1; bus_m.up_dn = 1;
        for (int i = 0; i < 7; i++) step();
        check("pre_rst_count", 32'(bus_m.count), 37);
        check("pre_rst_err", 32'(bus_m.load_err), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(bus_m.count), 0);
        check("async_rst_err", 32'(bus_m.load_err), 0);
        step();
        check("rst_hold_1", 32'(bus_m.count), 0);
        step();
        check("rst_hold_2", 32'(bus_m.count), 0);
        rst_n = 1'b1;
        step();
        check("rst_release", 32'(bus_m.count), 1);
        bus_m.en = 0;

`ifdef MOD_COUNTER_BCD_OUT_EN
        bus_m.load = 1; bus_m.load_val = 6'd47;
        step();
        bus_m.load = 0;
        check("bcd_count47", 32'(bus_m.count), 47);
        step();
        check("bcd_tens47", 32'(m_tens), 4);
        check("bcd_ones47", 32'(m_ones), 7);
        bus_m.load = 1; bus_m.load_val = 6'd59;
        step();
        bus_m.load = 0; bus_m.en = 1;
        step();
        bus_m.en = 0;
        check("bcd_wrap_count", 32'(bus_m.count), 0);
        check("bcd_lag_tens", 32'(m_tens), 5);
        check("bcd_lag_ones", 32'(m_ones), 9);
        step();
        check("bcd_tens0", 32'(m_tens), 0);
        check("bcd_ones0", 32'(m_ones), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
